// File: rtl/abc_unpack.sv
// abc_unpack: sequential inverse of the A*B+C multiply-add datapath.
// Given DATA = A*B + C with B and C known, recovers A = (DATA - C) / B
// with a restoring shift-subtract divider (one quotient bit per clock).
// It also returns the remainder and flags inputs that no L-bit
// (A, B, C) triple could have produced.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures
// DATA/B/C and raises busy. start while busy is ignored (no queueing).
// busy stays high until the result edge, where done pulses for exactly
// one cycle alongside fresh A/R/err. start may be high in the done cycle
// and is accepted on that edge.
//
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   start      - request pulse, accepted in IDLE
//   DATA       - 2L-bit packed value to decode
//   B, C       - L-bit divisor and addend operands
//   A, R       - registered quotient and remainder
//   err        - registered invalid-input flag for the last transaction
//   busy, done - transaction in flight / one-cycle result strobe
//   state_dbg  - current FSM state (0 IDLE, 1 PREP, 2 DIV)
module abc_unpack #(
    parameter int lenght = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*lenght-1:0]   DATA,
    input  logic [lenght-1:0]     B,
    input  logic [lenght-1:0]     C,
    output logic [lenght-1:0]     A,
    output logic [lenght-1:0]     R,
    output logic                  err,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int L  = lenght;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*L-1:0] data_q, data_d;
    logic [L-1:0]   b_q, b_d, c_q, c_d;
    logic [L-1:0]   rem_q, rem_d, dvd_q, dvd_d, quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [L-1:0]   a_d, r_d;
    logic           err_d, busy_d, done_d;

    // Operand check and first partial remainder.
    logic [2*L-1:0] n;
    logic           prep_err;
    assign n        = data_q - {{L{1'b0}}, c_q};
    assign prep_err = (b_q == '0) ||
                      (data_q < {{L{1'b0}}, c_q}) ||
                      (n[2*L-1:L] >= b_q);   // quotient would need > L bits

    // One restoring step. rem < B, so {rem, bit} <= 2B-1 fits in L+1 bits.
    logic [L:0]   ext, bext, trial;
    logic         take;
    logic [L-1:0] rem_nx, quo_nx;
    assign ext    = {rem_q, dvd_q[L-1]};
    assign bext   = {1'b0, b_q};
    assign trial  = ext - bext;
    assign take   = (ext >= bext);
    assign rem_nx = take ? trial[L-1:0] : ext[L-1:0];
    assign quo_nx = {quo_q[L-2:0], take};

    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PREP;
            PREP:    state_d = prep_err ? IDLE : DIV;
            DIV:     if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        data_d = data_q;
        b_d    = b_q;
        c_d    = c_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        a_d    = A;
        r_d    = R;
        err_d  = err;
        busy_d = busy;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d = DATA;
                    b_d    = B;
                    c_d    = C;
                    busy_d = 1'b1;
                end
            end
            PREP: begin
                if (prep_err) begin
                    err_d  = 1'b1;
                    a_d    = '0;
                    r_d    = '0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    rem_d = n[2*L-1:L];
                    dvd_d = n[L-1:0];
                    quo_d = '0;
                    cnt_d = CW'(L - 1);
                end
            end
            DIV: begin
                rem_d = rem_nx;
                dvd_d = dvd_q << 1;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    a_d    = quo_nx;
                    r_d    = rem_nx;
                    err_d  = 1'b0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            b_q    <= '0;
            c_q    <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            A      <= '0;
            R      <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            data_q <= data_d;
            b_q    <= b_d;
            c_q    <= c_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            A      <= a_d;
            R      <= r_d;
            err    <= err_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_abc_unpack.sv
module tb_abc_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] DATA;
    logic [7:0]  B, C, A, R;
    logic        err, busy, done;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    abc_unpack #(.lenght(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .DATA(DATA), .B(B), .C(C),
        .A(A), .R(R), .err(err), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for done with a cycle budget; returns edges waited and busy cycles seen.
    task automatic wait_done(output int lat, output int bcyc);
        bit got;
        lat = 0; bcyc = 0; got = 0;
        while (!got && lat < 40) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
    endtask

    // One full transaction; operands are scrambled after acceptance so an
    // in-flight result must come from the captured copies.
    task automatic run_op(input logic [15:0] d, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] ea, input logic [7:0] er, input logic ee,
                          input int elat, input string tag);
        int lat, bcyc;
        DATA = d; B = b; C = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        DATA = 16'($urandom); B = 8'($urandom); C = 8'($urandom);
        check({tag, " busy_after_accept"}, busy, 1);
        wait_done(lat, bcyc);
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_cycles"}, bcyc, elat);
        check({tag, " A"}, A, ea);
        check({tag, " R"}, R, er);
        check({tag, " err"}, err, ee);
        check({tag, " busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " A_hold"}, A, ea);
    endtask

    initial begin
        int lat, bcyc, dcnt;
        logic [7:0]  ra, rb, rc;
        logic [15:0] rd;
        logic        rerr;
        logic [15:0] nn;

        rst = 1'b1; start = 1'b0; DATA = '0; B = '0; C = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset A", A, 0);
        check("reset R", R, 0);
        check("reset err", err, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset state", state_dbg, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed decodes
        run_op(16'd226,   8'd17,  8'd5,   8'd13,  8'd0, 1'b0, 9, "exact");
        run_op(16'd230,   8'd17,  8'd5,   8'd13,  8'd4, 1'b0, 9, "remainder");
        run_op(16'd65280, 8'd255, 8'd255, 8'd255, 8'd0, 1'b0, 9, "full_scale");

        // Error cases
        run_op(16'd100,  8'd0,  8'd0, 8'd0, 8'd0, 1'b1, 1, "err_b_zero");
        run_op(16'd3,    8'd17, 8'd5, 8'd0, 8'd0, 1'b1, 1, "err_borrow");
        run_op(16'd4096, 8'd16, 8'd0, 8'd0, 8'd0, 1'b1, 1, "err_overflow");

        // start held high for 20 cycles with constant operands
        DATA = 16'd226; B = 8'd17; C = 8'd5; start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                check("hold_start A", A, 13);
                check("hold_start err", err, 0);
            end
        end
        start = 1'b0;
        check("hold_start done_count", dcnt, 2);
        @(posedge clk); #1;
        check("hold_start idle_after", busy, 0);

        // Back-to-back: new start in the done cycle is accepted
        DATA = 16'd226; B = 8'd17; C = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; DATA = 16'd999; B = 8'd3; C = 8'd1;
        wait_done(lat, bcyc);
        check("b2b_first latency", lat, 9);
        check("b2b_first A", A, 13);
        run_op(16'd230, 8'd17, 8'd5, 8'd13, 8'd4, 1'b0, 9, "b2b_second");

        // Reset at the 4th DIV cycle
        run_op(16'd230, 8'd17, 8'd5, 8'd13, 8'd4, 1'b0, 9, "pre_reset");
        DATA = 16'd226; B = 8'd17; C = 8'd5; start = 1'b1;
        @(posedge clk); #1;            // E0
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end   // E1..E4
        check("mid_reset state_div", state_dbg, 2);
        rst = 1'b1;
        @(posedge clk); #1;            // E5 under reset
        rst = 1'b0;
        check("mid_reset A", A, 0);
        check("mid_reset R", R, 0);
        check("mid_reset err", err, 0);
        check("mid_reset busy", busy, 0);
        check("mid_reset state", state_dbg, 0);
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("mid_reset no_done", dcnt, 0);
        run_op(16'd226, 8'd17, 8'd5, 8'd13, 8'd0, 1'b0, 9, "post_reset");

        // Random exact decodes: DATA = A*B + C
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rc = 8'($urandom_range(0, 255));
            rd = 16'(ra) * 16'(rb) + 16'(rc);
            run_op(rd, rb, rc, ra, 8'd0, 1'b0, 9, $sformatf("rand_exact%0d", i));
        end

        // Random DATA against a reference division
        for (int i = 0; i < 200; i++) begin
            rd = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            nn = rd - 16'(rc);
            rerr = (rb == 0) || (rd < 16'(rc)) || (nn[15:8] >= rb);
            if (rerr)
                run_op(rd, rb, rc, 8'd0, 8'd0, 1'b1, 1, $sformatf("rand_data%0d", i));
            else begin
                run_op(rd, rb, rc, 8'(nn / 16'(rb)), 8'(nn % 16'(rb)), 1'b0, 9,
                       $sformatf("rand_data%0d", i));
                check($sformatf("rand_data%0d identity", i),
                      32'(A) * 32'(rb) + 32'(R) + 32'(rc), 32'(rd));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/abc_unpack.md
Name: abc_unpack

Overview:
- Sequential inverse of the A*B+C multiply-add datapath.
- Given a packed result DATA and the known operands B and C, it recovers A = (DATA - C) / B with a restoring shift-subtract divider, one quotient bit per clock.
- It also returns the remainder and flags inputs that no (A, B, C) triple of the configured width could have produced.
- It sits on the consumer side of the multiply-add block and checks or reconstructs its operands.

Parameters:
- lenght, 8, operand width L in bits; DATA is 2*L bits wide.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- DATA  input  2*lenght  packed value to decode; sampled on the accepting edge.
- B  input  lenght  divisor operand; sampled on the accepting edge.
- C  input  lenght  addend operand; sampled on the accepting edge.
- A  output  lenght  recovered quotient; registered.
- R  output  lenght  remainder of (DATA-C)/B; registered.
- err  output  1  result invalid for the current transaction; registered.
- busy  output  1  high from the accepting edge until the result edge.
- done  output  1  one-cycle pulse marking new A/R/err.

Behaviour:
- Reset: rst high at a posedge forces state IDLE and sets A=0, R=0, err=0, busy=0, done=0. It also clears all internal registers.
- Reset mid-operation aborts the transaction. No done pulse follows.
- States: IDLE, PREP, DIV.
- IDLE:
  - If start=1, capture DATA, B and C, set busy=1 and go to PREP. This is edge E0.
  - start while busy is ignored; there is no queueing.
- PREP (edge E1): compute N = DATA_q - {L'b0, C_q} at 2L bits. err is set if any of these holds:
  - (a) B_q == 0;
  - (b) DATA_q < C_q (borrow);
  - (c) N[2L-1:L] >= B_q, meaning the quotient needs more than L bits.
- PREP on error: at E1 set err=1, A=0, R=0, done=1, busy=0 and return to IDLE.
- PREP otherwise: load the partial remainder with N[2L-1:L], the dividend shift register with N[L-1:0], and a bit counter with L-1. Go to DIV.
- DIV, one iteration per edge:
  - Form an (L+1)-bit trial = {rem, next dividend MSB} - {1'b0, B_q}.
  - If there is no borrow, rem = trial[L-1:0] and the quotient bit is 1.
  - Otherwise rem = {rem, bit}[L-1:0] and the quotient bit is 0.
  - Quotient bits shift in from the LSB.
- DIV completion: after L iterations (final edge E(L+1)), A = quotient, R = rem, err = 0, done = 1, busy = 0, and the state returns to IDLE.
- Latency:
  - Valid result: done is high in the cycle after edge E(L+1), i.e. L+1 edges after acceptance.
  - Error result: done follows edge E1.
- done: high exactly one cycle, then 0.
- A, R and err hold their values until the next transaction's result edge or a reset.
- Back-to-back: start may be high in the same cycle as done (state already IDLE) and is accepted on that edge.
- Result guarantee: for every non-error case, A*B + R + C == DATA and R < B. All arithmetic is unsigned.
- The intermediate trial subtraction must be L+1 bits wide so that rem values up to B-1 shifted left cannot overflow.

Test Plan:
- Exact decode (lenght=8): DATA=226, B=17, C=5, pulse start -> done 9 edges after acceptance with A=13, R=0, err=0; busy high for those 9 cycles.
- Remainder and full scale: DATA=230, B=17, C=5 -> A=13, R=4. Then DATA=65280, B=255, C=255 -> A=255, R=0, err=0.
- Error cases, each giving done 1 edge after acceptance, err=1, A=0, R=0:
  - B=0 with DATA=100, C=0;
  - DATA=3, C=5 (borrow);
  - DATA=4096, B=16, C=0 (quotient 256 overflows).
- Protocol: start held high for 20 cycles with constant operands (DATA=226, B=17, C=5) -> done pulses for each transaction and every result is A=13. Operands changed while busy do not affect the in-flight result. A new start in the done cycle is accepted.
- Reset mid-operation: assert rst for one edge at the 4th DIV cycle -> A=0, R=0, err=0, busy=0, and no done pulse. A following start with DATA=226, B=17, C=5 yields A=13 normally.
- Randomised self-check: 1000 random A, B (B≠0) and C, with DATA=A*B+C -> the recovered A matches and R=0 every time. Random DATA values also satisfy A*B+R+C==DATA whenever err=0.
